cancellable_timer_bank: RTL and testbench

- Bank of NUM_CH independent one-shot delay timers. Each timer can be disabled before it expires, individually or all at once.
- Synthesizable, parametrised successor to the "timed block killed by disable" construct: start = enter the block, expiry = block body executes, cancel = disable block_id.
- Used by sequencers and test harnesses that need abortable timeouts. Cancel beats expiry on a tie.

---
 rtl/cancellable_timer_bank.sv | 59 +++++
 tb/tb_cancellable_timer_bank.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cancellable_timer_bank.sv
// cancellable_timer_bank: bank of abortable one-shot delay timers, start-while-running reloads when CANCELLABLE_TIMER_RETRIGGER_EN is defined
module cancellable_timer_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH*CNT_W-1:0]   delay,
  input  logic [NUM_CH-1:0]         cancel,
  input  logic                      cancel_all,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         fire,
  output logic [NUM_CH-1:0]         cancelled,
  output logic                      any_busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [NUM_CH-1:0] busy_nxt;
  for (genvar i = 0; i < NUM_CH; i++) begin : ch
    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, d, load;
    logic             kill, running, last, restart, launch, fire_q, canc_q;
    assign d       = delay[i*CNT_W +: CNT_W];
    assign load    = (|d) ? d : CNT_W'(1);
    assign kill    = cancel[i] | cancel_all;
    assign running = state == RUN;
    assign last    = cnt == CNT_W'(1);
`ifdef CANCELLABLE_TIMER_RETRIGGER_EN
    assign restart = running & start[i] & ~kill;
`else
    assign restart = 1'b0;
`endif
    assign launch    = ~running & start[i] & ~kill;
    assign state_nxt = kill ? IDLE : running ? ((last & ~restart) ? IDLE : RUN) : (launch ? RUN : IDLE);
    assign cnt_nxt   = (launch | restart) ? load : (running & ~kill & ~last) ? cnt - CNT_W'(1) : cnt;
    assign busy_nxt[i] = state_nxt == RUN;
    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= IDLE;
        cnt    <= '0;
        fire_q <= 1'b0;
        canc_q <= 1'b0;
      end else begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        fire_q <= running & ~kill & last & ~restart;
        canc_q <= running & kill;
      end
    end
    assign busy[i]      = running;
    assign fire[i]      = fire_q;
    assign cancelled[i] = canc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) any_busy <= 1'b0;
    else any_busy <= |busy_nxt;
  end
endmodule

// File: tb/tb_cancellable_timer_bank.sv
// tb_cancellable_timer_bank: directed self-checking bench for cancellable_timer_bank
module tb_cancellable_timer_bank;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  start = '0;
  logic [31:0] delay = '0;
  logic [3:0]  cancel = '0;
  logic        cancel_all = 1'b0;
  logic [3:0]  busy, fire, cancelled;
  logic        any_busy;
  int          n_checks = 0;
  int          n_fail = 0;
  cancellable_timer_bank #(.NUM_CH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .delay(delay), .cancel(cancel),
    .cancel_all(cancel_all), .busy(busy), .fire(fire), .cancelled(cancelled), .any_busy(any_busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if ({busy, fire, cancelled, any_busy} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", {busy, fire, cancelled, any_busy});
    end
    reset = 1'b0;
    step();
    n_checks++;
    if ({busy, fire, cancelled, any_busy} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=0", {busy, fire, cancelled, any_busy});
    end
  endtask
  task automatic test_basic();
    delay[7:0] = 8'd4;
    start = 4'b0001;
    step();
    start = '0;
    for (int k = 0; k <= 5; k++) begin
      if (k >= 1) begin
        n_checks++;
        if (busy[0] !== (k <= 3) || any_busy !== (k <= 3)) begin
          n_fail++;
          $display("FAIL basic_busy k=%0d got=%b/%b exp=%b", k, busy[0], any_busy, k <= 3);
        end
      end
      n_checks++;
      if (fire !== ((k == 4) ? 4'b0001 : 4'b0000) || cancelled !== 4'b0) begin
        n_fail++;
        $display("FAIL basic_fire k=%0d got fire=%b canc=%b", k, fire, cancelled);
      end
      step();
    end
  endtask
  task automatic test_cancel();
    delay[15:8] = 8'd4;
    start = 4'b0010;
    step();
    start = '0;
    for (int k = 0; k <= 5; k++) begin
      n_checks++;
      if (cancelled !== ((k == 3) ? 4'b0010 : 4'b0000) || fire !== 4'b0) begin
        n_fail++;
        $display("FAIL cancel_pulse k=%0d got canc=%b fire=%b", k, cancelled, fire);
      end
      if (k >= 1) begin
        n_checks++;
        if (busy[1] !== (k < 3)) begin
          n_fail++;
          $display("FAIL cancel_busy k=%0d got=%b exp=%b", k, busy[1], k < 3);
        end
      end
      cancel = (k == 2) ? 4'b0010 : 4'b0000;
      step();
    end
  endtask
  task automatic test_tie();
    delay[23:16] = 8'd3;
    start = 4'b0100;
    step();
    start = '0;
    for (int k = 0; k <= 5; k++) begin
      n_checks++;
      if (cancelled !== ((k == 3) ? 4'b0100 : 4'b0000) || fire !== 4'b0) begin
        n_fail++;
        $display("FAIL tie k=%0d got canc=%b fire=%b", k, cancelled, fire);
      end
      cancel_all = (k == 2);
      step();
    end
  endtask
  task automatic test_cancel_idle();
    start = 4'b0001;
    cancel = 4'b0001;
    step();
    start = '0;
    cancel = '0;
    n_checks++;
    if (busy !== 4'b0 || cancelled !== 4'b0 || any_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_idle got busy=%b canc=%b", busy, cancelled);
    end
    step();
  endtask
  task automatic test_edge_delays();
    int first_k, n_fire;
    delay[7:0] = 8'd0;
    delay[31:24] = 8'd255;
    start = 4'b1001;
    step();
    start = '0;
    first_k = -1;
    n_fire = 0;
    for (int k = 0; k <= 258; k++) begin
      if (k <= 1) begin
        n_checks++;
        if (fire[0] !== (k == 1)) begin
          n_fail++;
          $display("FAIL delay0_fire k=%0d got=%b exp=%b", k, fire[0], k == 1);
        end
      end
      if (k == 254) begin
        n_checks++;
        if (busy !== 4'b1000) begin
          n_fail++;
          $display("FAIL delay255_busy got=%b exp=1000", busy);
        end
      end
      if (fire[3]) begin
        n_fire++;
        if (first_k < 0) first_k = k;
      end
      step();
    end
    n_checks++;
    if (first_k != 255 || n_fire != 1) begin
      n_fail++;
      $display("FAIL delay255_fire got first=%0d count=%0d exp first=255 count=1", first_k, n_fire);
    end
  endtask
  task automatic test_reset_mid();
    delay = {4{8'd10}};
    start = 4'b1111;
    step();
    start = '0;
    for (int k = 0; k <= 15; k++) begin
      if (k == 4) begin
        n_checks++;
        if (busy !== 4'b1111 || any_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_mid_pre got busy=%b any=%b exp 1111/1", busy, any_busy);
        end
      end
      if (k >= 5) begin
        n_checks++;
        if ({busy, fire, cancelled, any_busy} !== 13'h0) begin
          n_fail++;
          $display("FAIL reset_mid k=%0d got=%h exp=0", k, {busy, fire, cancelled, any_busy});
        end
      end
      if (k == 4) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    step();
    step();
  endtask
  task automatic test_restart();
    int exp_k;
`ifdef CANCELLABLE_TIMER_RETRIGGER_EN
    exp_k = 7;
`else
    exp_k = 5;
`endif
    delay[31:24] = 8'd5;
    start = 4'b1000;
    step();
    start = '0;
    for (int k = 0; k <= 9; k++) begin
      n_checks++;
      if (fire !== ((k == exp_k) ? 4'b1000 : 4'b0000) || cancelled !== 4'b0) begin
        n_fail++;
        $display("FAIL restart k=%0d got fire=%b canc=%b exp fire at %0d", k, fire, cancelled, exp_k);
      end
      start = (k == 1) ? 4'b1000 : 4'b0000;
      step();
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_cancel();
    test_tie();
    test_cancel_idle();
    test_edge_delays();
    test_reset_mid();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
